// File: rtl/axi_wr_n_merger_if.sv
// One AXI write bus (AW/W/B) with N side-by-side lanes; lane i lives at slice i of every field.
// master drives AW/W and accepts B, slave is the mirror image.
interface axi_wr_n_merger_if #(
   parameter int N      = 1,
   parameter int IDW    = 4,
   parameter int DW     = 64,
   parameter int EXTRAS = 8
);
   localparam int SW = DW/8;

   logic [N*IDW-1:0]    awid;
   logic [N*32-1:0]     awaddr;
   logic [N*8-1:0]      awlen;
   logic [N*EXTRAS-1:0] awextras;
   logic [N*2-1:0]      awburst;
   logic [N-1:0]        awvalid;
   logic [N-1:0]        awready;
   logic [N*DW-1:0]     wdata;
   logic [N*SW-1:0]     wstrb;
   logic [N-1:0]        wlast;
   logic [N-1:0]        wvalid;
   logic [N-1:0]        wready;
   logic [N*IDW-1:0]    bid;
   logic [N*2-1:0]      bresp;
   logic [N-1:0]        bvalid;
   logic [N-1:0]        bready;

   modport master (
      output awid, awaddr, awlen, awextras, awburst, awvalid,
      output wdata, wstrb, wlast, wvalid,
      output bready,
      input  awready, wready, bid, bresp, bvalid
   );

   modport slave (
      input  awid, awaddr, awlen, awextras, awburst, awvalid,
      input  wdata, wstrb, wlast, wvalid,
      input  bready,
      output awready, wready, bid, bresp, bvalid
   );
endinterface

// File: rtl/axi_wr_n_merger.sv
// NUM-to-1 AXI write merger: RR AW grant (min 1 cycle push->awvalid, held while stalled), W follows grant order and B routes by AWID prefix, both zero latency.
// Backpressure: s_awready = per-port AW FIFO not full; AXI_MERGE_ERRCNT_EN adds per-port saturating error-response counters.
module axi_wr_n_merger #(
   parameter int NUM     = 4,
   parameter int IDWID   = 4,
   parameter int PW      = (NUM > 1) ? $clog2(NUM) : 1,
   parameter int DWID    = 64,
   parameter int WSTRB   = DWID/8,
   parameter int EXTRAS  = 8,
   parameter int AWDEPTH = 2,
   parameter int WORDER  = 4,
   parameter int OUTST   = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   axi_wr_n_merger_if.slave   s_if,
   axi_wr_n_merger_if.master  m_if,
   output logic [NUM*16-1:0]  o_err_count
);
   // FIFO depths are powers of two and at least 2, so the extra MSB tells full from empty.
   localparam int AWA = $clog2(AWDEPTH);
   localparam int ORA = $clog2(WORDER);
   localparam int OCW = $clog2(OUTST+1);

   typedef struct packed {
      logic [IDWID-1:0]  id;
      logic [31:0]       addr;
      logic [7:0]        len;
      logic [EXTRAS-1:0] extras;
      logic [1:0]        burst;
   } aw_t;

   aw_t            r_aw_mem [NUM][AWDEPTH];
   logic [AWA:0]   r_aw_wp  [NUM];
   logic [AWA:0]   r_aw_rp  [NUM];
   logic [OCW-1:0] r_outst  [NUM];
   aw_t            w_aw_in  [NUM];
   logic [NUM-1:0] w_aw_full;
   logic [NUM-1:0] w_aw_empty;
   logic [NUM-1:0] w_aw_push;
   logic [NUM-1:0] w_elig;
   logic [NUM-1:0] w_inc;
   logic [NUM-1:0] w_dec;

   logic [PW-1:0]  r_ord_mem [WORDER];
   logic [ORA:0]   r_ord_wp;
   logic [ORA:0]   r_ord_rp;
   logic           w_ord_full;
   logic           w_ord_empty;
   logic           w_ord_pop;
   logic [PW-1:0]  w_h;

   logic [PW-1:0]  r_last;
   logic [PW-1:0]  r_lock_port;
   logic           r_lock;
   logic [PW-1:0]  w_pick;
   logic [PW-1:0]  w_gnt;
   logic           w_any;
   logic           w_awvalid;
   logic           w_aw_hs;
   aw_t            w_head;

   logic           w_wvalid;
   logic           w_wlast;
   logic [NUM-1:0] w_wready_v;

   logic [PW-1:0]  w_bp;
   logic           w_bp_ok;
   logic           w_bready;
   logic [NUM-1:0] w_bvalid_v;

   // ---------------- per-port AW FIFOs and outstanding counters ----------------
   always_comb begin
      for (int i = 0; i < NUM; i++) begin
         w_aw_in[i].id     = s_if.awid[i*IDWID +: IDWID];
         w_aw_in[i].addr   = s_if.awaddr[i*32 +: 32];
         w_aw_in[i].len    = s_if.awlen[i*8 +: 8];
         w_aw_in[i].extras = s_if.awextras[i*EXTRAS +: EXTRAS];
         w_aw_in[i].burst  = s_if.awburst[i*2 +: 2];
      end
   end

   always_comb begin
      for (int i = 0; i < NUM; i++) begin
         w_aw_empty[i] = (r_aw_wp[i] == r_aw_rp[i]);
         w_aw_full[i]  = (r_aw_wp[i][AWA] != r_aw_rp[i][AWA]) &&
                         (r_aw_wp[i][AWA-1:0] == r_aw_rp[i][AWA-1:0]);
         w_aw_push[i]  = s_if.awvalid[i] && !w_aw_full[i];
         w_elig[i]     = !w_aw_empty[i] && (r_outst[i] < OCW'(OUTST)) && !w_ord_full;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM; i++) begin
         w_inc[i] = w_aw_hs && (w_gnt == PW'(i));
         w_dec[i] = w_bvalid_v[i] && s_if.bready[i];
      end
   end

   always_ff @(posedge i_clk) begin
      for (int i = 0; i < NUM; i++) begin
         if (w_aw_push[i]) begin
            r_aw_mem[i][r_aw_wp[i][AWA-1:0]] <= w_aw_in[i];
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < NUM; i++) begin
            r_aw_wp[i] <= '0;
            r_aw_rp[i] <= '0;
            r_outst[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM; i++) begin
            if (w_aw_push[i]) r_aw_wp[i] <= r_aw_wp[i] + 1'b1;
            if (w_inc[i])     r_aw_rp[i] <= r_aw_rp[i] + 1'b1;
            // A stray B at zero must not wrap, or the port would be locked out.
            if (w_inc[i] && !w_dec[i]) begin
               r_outst[i] <= r_outst[i] + 1'b1;
            end else if (w_dec[i] && !w_inc[i] && (r_outst[i] != '0)) begin
               r_outst[i] <= r_outst[i] - 1'b1;
            end
         end
      end
   end

   // ---------------- round-robin arbiter with grant lock ----------------
   always_comb begin
      int idx;
      idx    = 0;
      w_any  = 1'b0;
      w_pick = r_last;
      for (int k = 1; k <= NUM; k++) begin
         idx = (int'(r_last) + k) % NUM;
         if (!w_any && w_elig[idx]) begin
            w_any  = 1'b1;
            w_pick = PW'(idx);
         end
      end
   end

   assign w_gnt     = r_lock ? r_lock_port : w_pick;
   assign w_awvalid = r_lock || w_any;
   assign w_aw_hs   = w_awvalid && m_if.awready;
   assign w_head    = r_aw_mem[w_gnt][r_aw_rp[w_gnt][AWA-1:0]];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_last      <= PW'(NUM-1);
         r_lock      <= 1'b0;
         r_lock_port <= '0;
      end else if (w_aw_hs) begin
         r_last <= w_gnt;
         r_lock <= 1'b0;
      end else if (w_awvalid) begin
         r_lock      <= 1'b1;
         r_lock_port <= w_gnt;
      end
   end

   assign m_if.awvalid  = w_awvalid;
   assign m_if.awid     = {w_gnt, w_head.id};
   assign m_if.awaddr   = w_head.addr;
   assign m_if.awlen    = w_head.len;
   assign m_if.awextras = w_head.extras;
   assign m_if.awburst  = w_head.burst;
   assign s_if.awready  = ~w_aw_full;

   // ---------------- W order FIFO and data mux ----------------
   assign w_ord_empty = (r_ord_wp == r_ord_rp);
   assign w_ord_full  = (r_ord_wp[ORA] != r_ord_rp[ORA]) &&
                        (r_ord_wp[ORA-1:0] == r_ord_rp[ORA-1:0]);
   assign w_h         = r_ord_mem[r_ord_rp[ORA-1:0]];
   assign w_ord_pop   = w_wvalid && m_if.wready && w_wlast;

   always_ff @(posedge i_clk) begin
      if (w_aw_hs) r_ord_mem[r_ord_wp[ORA-1:0]] <= w_gnt;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ord_wp <= '0;
         r_ord_rp <= '0;
      end else begin
         if (w_aw_hs)   r_ord_wp <= r_ord_wp + 1'b1;
         if (w_ord_pop) r_ord_rp <= r_ord_rp + 1'b1;
      end
   end

   always_comb begin
      w_wvalid        = !w_ord_empty && s_if.wvalid[w_h];
      w_wlast         = s_if.wlast[w_h];
      w_wready_v      = '0;
      w_wready_v[w_h] = m_if.wready && !w_ord_empty;
   end

   assign m_if.wvalid = w_wvalid;
   assign m_if.wlast  = w_wlast;
   assign m_if.wdata  = s_if.wdata[int'(w_h)*DWID +: DWID];
   assign m_if.wstrb  = s_if.wstrb[int'(w_h)*WSTRB +: WSTRB];
   assign s_if.wready = w_wready_v;

   // ---------------- B routing by AWID prefix ----------------
   assign w_bp    = m_if.bid[PW+IDWID-1:IDWID];
   assign w_bp_ok = (int'(w_bp) < NUM);

   always_comb begin
      w_bvalid_v = '0;
      w_bready   = 1'b1;
      if (w_bp_ok) begin
         w_bvalid_v[w_bp] = m_if.bvalid;
         w_bready         = s_if.bready[w_bp];
      end
   end

   assign m_if.bready = w_bready;
   assign s_if.bvalid = w_bvalid_v;
   assign s_if.bid    = {NUM{m_if.bid[IDWID-1:0]}};
   assign s_if.bresp  = {NUM{m_if.bresp}};

   // ---------------- optional error-response counters ----------------
`ifdef AXI_MERGE_ERRCNT_EN
   logic [15:0] r_err [NUM];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < NUM; i++) r_err[i] <= '0;
      end else begin
         for (int i = 0; i < NUM; i++) begin
            if (w_dec[i] && m_if.bresp[1] && (r_err[i] != 16'hFFFF)) begin
               r_err[i] <= r_err[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM; i++) o_err_count[i*16 +: 16] = r_err[i];
   end
`else
   assign o_err_count = '0;
`endif

endmodule
